adder_chunked_seq: RTL and testbench

- Multi-cycle, parametrised adder/subtractor.
- Splits a BIT_WIDTH-wide operation into CHUNK_WIDTH slices and computes one slice per clock, with the carry held in a register between slices.
- Trades latency for a short carry chain in wide datapaths.
- Adds a start/busy/done handshake, a subtract mode, and both unsigned carry-out and signed overflow flags.

---
 rtl/adder_chunked_seq_if.sv | 25 ++
 rtl/adder_chunked_seq.sv | 104 ++++++++++
 tb/tb_adder_chunked_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_chunked_seq_if.sv
// Handshake and operand/result bundle for the chunked sequential adder.
interface adder_chunked_seq_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 start;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 carry_in;
    logic                 sub;
    logic                 busy;
    logic                 done;
    logic [BIT_WIDTH-1:0] sum;
    logic                 carry_out;
    logic                 overflow;

    modport master (
        output start, a, b, carry_in, sub,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, a, b, carry_in, sub,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_chunked_seq.sv
// Multi-cycle add/subtract: one CHUNK_WIDTH slice per clock, carry held in a
// register between slices; results are published only when the last slice lands.
module adder_chunked_seq #(
    parameter int BIT_WIDTH   = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    adder_chunked_seq_if.slave  bus
);
    localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
    localparam int KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int MSB        = BIT_WIDTH - 1;

    generate
        if (BIT_WIDTH < 2 || CHUNK_WIDTH < 1 || (BIT_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
            $error("adder_chunked_seq: BIT_WIDTH must be >= 2 and a multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_e;

    state_e                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   a_q, b_q, acc_q, acc_d;
    logic                   carry_q;
    logic [KW-1:0]          k_q;
    logic [BIT_WIDTH-1:0]   sum_q;
    logic                   carry_out_q, overflow_q, done_q;
    logic                   accept, last;
    logic [CHUNK_WIDTH:0]   slice_full;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = done_q;
        bus.sum       = sum_q;
        bus.carry_out = carry_out_q;
        bus.overflow  = overflow_q;
    end

    always_comb begin
        accept     = (state_q == IDLE) && bus.start;
        last       = (state_q == RUN) && (k_q == KW'(NUM_CHUNKS - 1));
        slice_full = {1'b0, a_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH]}
                   + {1'b0, b_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH]}
                   + (CHUNK_WIDTH+1)'(carry_q);
        acc_d = acc_q;
        acc_d[k_q*CHUNK_WIDTH +: CHUNK_WIDTH] = slice_full[CHUNK_WIDTH-1:0];
    end

    // b is stored already inverted for subtraction so RUN never looks at mode
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.sub ? ~bus.b : bus.b;
                carry_q <= bus.sub ? 1'b1 : bus.carry_in;
                k_q     <= '0;
            end else if (state_q == RUN) begin
                acc_q   <= acc_d;
                carry_q <= slice_full[CHUNK_WIDTH];
                k_q     <= k_q + KW'(1);
                if (last) begin
                    sum_q       <= acc_d;
                    carry_out_q <= slice_full[CHUNK_WIDTH];
                    overflow_q  <= (a_q[MSB] == b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
                    done_q      <= 1'b1;
                end
            end
        end
    end

    a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({bus.start, bus.sub, bus.carry_in}))
        else $error("adder_chunked_seq: X/Z on start, sub or carry_in");

    a_operands_known: assert property (@(posedge clk) disable iff (rst)
        (bus.start && state_q == IDLE) |-> !$isunknown({bus.a, bus.b}))
        else $error("adder_chunked_seq: X/Z on a or b at accepted start");
endmodule

// File: tb/tb_adder_chunked_seq.sv
// Self-checking bench for adder_chunked_seq: directed table, handshake corner
// sequences, and randomized operations against an integer-arithmetic model.
module tb_adder_chunked_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    adder_chunked_seq_if #(.BIT_WIDTH(16)) bus ();

    adder_chunked_seq #(.BIT_WIDTH(16), .CHUNK_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, signed range check for overflow.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [15:0] s, output logic c, output logic o);
        int ua, ub, sa, sb, u, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            u  = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            u  = ua + ub + int'(mcin);
            sr = sa + sb + int'(mcin);
            c  = (u > 65535);
        end
        s = u[15:0];
        o = (sr > 32767) || (sr < -32768);
    endfunction

    // Starts an operation from idle, scrambles inputs while busy, waits for done.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub, output logic [15:0] s, output logic c,
                          output logic o, output int lat, output bit busy_ok);
        bus.a        = ta;
        bus.b        = tb_;
        bus.carry_in = tcin;
        bus.sub      = tsub;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.carry_in = 1'($urandom);
            bus.sub      = 1'($urandom);
            step();
            lat++;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        s = bus.sum;
        c = bus.carry_out;
        o = bus.overflow;
    endtask

    vec_t        vecs[7];
    logic [15:0] rs, ms, held;
    logic        rc, ro, mc, mo;
    int          lat;
    bit          bok;
    int          cyc;
    bit          saw_done;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{"add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{"add_0fff_1",   16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[2] = '{"add_7fff_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub_5_7",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"add_mixed",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6] = '{"sub_0_0",      16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
        bus.sub      = 1'b0;
        rst          = 1'b1;
        repeat (3) step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum",  32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.carry_out), 32'd0);
        check("reset_ovf",  32'(bus.overflow), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat, bok);
            check({vecs[i].name, "_lat"},  32'(lat), 32'd4);
            check({vecs[i].name, "_busy"}, 32'(bok), 32'd1);
            check({vecs[i].name, "_sum"},  32'(rs), 32'(vecs[i].s));
            check({vecs[i].name, "_cout"}, 32'(rc), 32'(vecs[i].c));
            check({vecs[i].name, "_ovf"},  32'(ro), 32'(vecs[i].o));
            held = bus.sum;
            step();
            check({vecs[i].name, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({vecs[i].name, "_hold"}, 32'(bus.sum), 32'(held));
        end

        // start pulsed mid-operation must be ignored
        bus.a = 16'h1111; bus.b = 16'h2222; bus.carry_in = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.a = 16'hF0F0; bus.b = 16'h0F0F; bus.sub = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 2;
        while (bus.done !== 1'b1 && cyc < 20) begin step(); cyc++; end
        check("ignore_lat",  32'(cyc), 32'd4);
        check("ignore_sum",  32'(bus.sum), 32'h3333);
        check("ignore_cout", 32'(bus.carry_out), 32'd0);
        check("ignore_ovf",  32'(bus.overflow), 32'd0);

        // start in the done cycle is accepted with zero gap
        bus.a = 16'h9000; bus.b = 16'h9000; bus.carry_in = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin step(); cyc++; end
        check("b2b_lat",  32'(cyc), 32'd4);
        check("b2b_sum",  32'(bus.sum), 32'h2000);
        check("b2b_cout", 32'(bus.carry_out), 32'd1);
        check("b2b_ovf",  32'(bus.overflow), 32'd1);
        step();

        // reset sampled at the end of the third RUN cycle aborts the operation
        bus.a = 16'hAAAA; bus.b = 16'h1111; bus.carry_in = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum",  32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.carry_out), 32'd0);
        check("abort_ovf",  32'(bus.overflow), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            step();
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_op(16'hAAAA, 16'h1111, 1'b0, 1'b0, rs, rc, ro, lat, bok);
        check("after_abort_lat", 32'(lat), 32'd4);
        check("after_abort_sum", 32'(rs), 32'hBBBB);
        check("after_abort_flags", 32'({rc, ro}), 32'd0);
        step();

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rcin, rsub;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rcin = 1'($urandom);
            rsub = 1'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'h7FFF;
            model(ra, rb, rcin, rsub, ms, mc, mo);
            run_op(ra, rb, rcin, rsub, rs, rc, ro, lat, bok);
            check("rand_lat",  32'(lat), 32'd4);
            check("rand_sum",  32'(rs), 32'(ms));
            check("rand_cout", 32'(rc), 32'(mc));
            check("rand_ovf",  32'(ro), 32'(mo));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
